// File: rtl/spi_ram_pkg.sv
// Shared widths, opcodes, FSM states and frame packing for the SPI RAM host.
package spi_ram_pkg;

  localparam int SPI_FRAME_W   = 18;
  localparam int SPI_PAYLOAD_W = SPI_FRAME_W - 2;
  localparam int SPI_ADDR_W    = 10;
  localparam int SPI_DATA_W    = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_ram_op_e;

  typedef enum logic [2:0] {
    IDLE,
    F1_TX,
    F1_WAIT,
    GAP,
    F2_TX,
    F2_WAIT,
    RESP
  } state_e;

  function automatic logic [SPI_FRAME_W-1:0] pack_frame(input spi_ram_op_e op,
                                                        input logic [SPI_PAYLOAD_W-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_ram_timer.sv
// Loadable down-counter with zero flag; serves both the inter-frame gap and the frame timeout.
module spi_ram_timer #(
  parameter int W = 8
) (
  input  logic         sys_clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge sys_clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_ram_host.sv
// Turns single-beat RAM read/write requests into two-frame SPI command sequences for spi_full_duplex.
module spi_ram_host
  import spi_ram_pkg::*;
#(
  parameter int FRAME_W        = SPI_FRAME_W,
  parameter int ADDR_W         = SPI_ADDR_W,
  parameter int DATA_W         = SPI_DATA_W,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [1:0]         cfg_spi_mode,
  input  logic [1:0]         cfg_clock_speed,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_error,
  output logic               busy,
  output logic               tx_enable,
  output logic [FRAME_W-1:0] data_in,
  output logic [1:0]         spi_mode,
  output logic [1:0]         clock_speed,
  input  logic [FRAME_W-1:0] master_out,
  input  logic               mrx_data_valid
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e             state;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               accept;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_zero;
  logic               unused_rx_bits;

  assign req_ready      = (state == IDLE) && !reset;
  assign accept         = req_valid && req_ready;
  assign busy           = (state != IDLE);
  assign unused_rx_bits = ^master_out[FRAME_W-1:DATA_W];

  // Loaded with N-1 so the count hits zero on the last allowed cycle of the window.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = TMR_W'(TIMEOUT_CYCLES - 1);
    if (state == IDLE && accept) begin
      tmr_load = 1'b1;
    end else if (state == F1_WAIT && mrx_data_valid) begin
      tmr_load  = 1'b1;
      tmr_value = TMR_W'(GAP_CYCLES - 1);
    end else if (state == GAP && tmr_zero) begin
      tmr_load = 1'b1;
    end
  end

  spi_ram_timer #(.W(TMR_W)) u_timer (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      tx_enable   <= 1'b0;
      data_in     <= '0;
      spi_mode    <= '0;
      clock_speed <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      tx_enable <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          write_q     <= req_write;
          wdata_q     <= req_wdata;
          spi_mode    <= cfg_spi_mode;
          clock_speed <= cfg_clock_speed;
          data_in     <= pack_frame(req_write ? WR_ADDR : RD_ADDR, SPI_PAYLOAD_W'(req_addr));
          tx_enable   <= 1'b1;
          state       <= F1_TX;
        end
        F1_TX: state <= F1_WAIT;
        F1_WAIT: begin
          // A response arriving on the expiry cycle still counts as success.
          if (mrx_data_valid) begin
            state <= GAP;
          end else if (tmr_zero) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        GAP: if (tmr_zero) begin
          data_in   <= write_q ? pack_frame(WR_DATA, SPI_PAYLOAD_W'(wdata_q))
                               : pack_frame(RD_DATA, '0);
          tx_enable <= 1'b1;
          state     <= F2_TX;
        end
        F2_TX: state <= F2_WAIT;
        F2_WAIT: begin
          if (mrx_data_valid) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= write_q ? '0 : master_out[DATA_W-1:0];
            state     <= RESP;
          end else if (tmr_zero) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_ram_host.md
# spi_ram_host

Host-side transaction sequencer that sits directly upstream of `spi_full_duplex`. It turns single-beat read/write requests into the two-frame SPI command sequence the RAM slave expects, drives the master's `tx_enable`, `data_in`, `spi_mode` and `clock_speed`, and consumes `master_out` and `mrx_data_valid` to return read data. It also enforces an inter-frame gap and a per-frame timeout.

## Interface
- `FRAME_W`, 18: SPI frame width; must match the master.
- `ADDR_W`, 10: RAM address width (1 kB).
- `DATA_W`, 8: RAM data width.
- `GAP_CYCLES`, 4: idle `sys_clock` cycles between a frame's completion and the next `tx_enable`; legal range 1..255.
- `TIMEOUT_CYCLES`, 4096: cycles allowed from `tx_enable` to `mrx_data_valid`.
- `sys_clock`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  RAM address.
- `req_wdata`  in  DATA_W  write data.
- `cfg_spi_mode`  in  2  SPI mode; sampled at accept.
- `cfg_clock_speed`  in  2  SCLK divider select; sampled at accept.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_error`  out  1  valid with `rsp_valid`; 1 = timeout.
- `busy`  out  1  high whenever the block is not in IDLE.
- `tx_enable`  out  1  to master; one-cycle launch pulse.
- `data_in`  out  FRAME_W  to master; frame to send.
- `spi_mode`  out  2  to master; held for the whole transaction.
- `clock_speed`  out  2  to master; held for the whole transaction.
- `master_out`  in  FRAME_W  from master; received frame.
- `mrx_data_valid`  in  1  from master; frame-complete pulse.

## Operation
- Frame format: bits [17:16] are the opcode; bits [15:0] are the payload, zero-extended.
  - 00 = write address: payload is `addr`.
  - 01 = write data: payload is `wdata`.
  - 10 = read address: payload is `addr`.
  - 11 = read data: payload is 0 (dummy).
- Write: two frames, 00 then 01. Read: two frames, 10 then 11. For a read, `rsp_rdata = master_out[DATA_W-1:0]` captured on the 11 frame's `mrx_data_valid`.
- FSM states:
  - IDLE: on accept, latch `addr`, `wdata`, `write` and cfg, then go to F1_TX.
  - F1_TX: pulse `tx_enable` with frame 1, then go to F1_WAIT.
  - F1_WAIT: on `mrx_data_valid` go to GAP; on timeout go to RESP with error.
  - GAP: count GAP_CYCLES, then go to F2_TX.
  - F2_TX: pulse `tx_enable` with frame 2, then go to F2_WAIT.
  - F2_WAIT: on `mrx_data_valid` capture read data and go to RESP; on timeout go to RESP with error.
  - RESP: pulse `rsp_valid`, then go to IDLE.
- `req_ready = (state == IDLE) && !reset`. Requests are never queued.
- `data_in` holds the last frame until the next F*_TX state.
- `mrx_data_valid` in any state other than F1_WAIT or F2_WAIT is ignored.
- Timeout: the counter reloads at every `tx_enable`. Error fires on the cycle the count reaches TIMEOUT_CYCLES with no `mrx_data_valid`.
- If `mrx_data_valid` and timeout expiry occur in the same cycle, `mrx_data_valid` wins (no error).
- Reset mid-transaction: abandon immediately and emit no response. The next transaction always restarts with an address frame.
- Reset values: all outputs 0, including `data_in`, `spi_mode`, `clock_speed` and `rsp_rdata`. `req_ready` is 0 while reset is asserted and 1 on the first cycle after release.

## Timing
- Accept at cycle T puts `tx_enable` high at T+1, for exactly one cycle.
- Frame-1 `mrx_data_valid` at cycle C puts frame-2 `tx_enable` at C+1+GAP_CYCLES.
- Final `mrx_data_valid` at cycle D puts `rsp_valid` at D+1, and `req_ready` at D+2.
- Back-to-back requests: the second request can be accepted at D+2 at the earliest.
- `spi_mode` and `clock_speed` update at T+1 and stay stable until the next accept.

## Structure
- Package `spi_ram_pkg` holds:
  - frame/address/data width constants;
  - opcode enum `spi_ram_op_e` (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA);
  - FSM state enum;
  - function `pack_frame(op, payload)` returning FRAME_W bits.
- Sub-module `spi_ram_timer`: one loadable down-counter with a zero flag, shared by the GAP and timeout functions, since they are never active at the same time.

## Test plan
- Write addr 0x155, data 0xA5 → frames 0x00155 then 0x100A5; `rsp_valid` with `rsp_error=0`.
- Read addr 0x155 after that write → frames 0x20155 then 0x30000; `rsp_rdata=0xA5`, `rsp_error=0`.
- GAP_CYCLES=4, model master returns `mrx_data_valid` 40 cycles after each launch → second `tx_enable` exactly 5 cycles after the first `mrx_data_valid`; `req_ready` low throughout.
- TIMEOUT_CYCLES=64, master never responds → `rsp_valid` and `rsp_error=1` at launch+64, `rsp_rdata=0`, back in IDLE. Repeat with `mrx_data_valid` on the expiry cycle → no error.
- Reset asserted for one cycle during F2_WAIT → no `rsp_valid`; all outputs 0; the next read issues an address frame first.
- Stray `mrx_data_valid` in IDLE and GAP, plus `req_valid` held during busy → ignored; exactly one accept per transaction; cfg changes mid-transaction do not alter `spi_mode`.
